// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the writeback arbiter.
package wb_arbiter_pkg;

    localparam int DEF_XLEN       = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// ALU/LSU result streams in, register file write port out.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic                  i_aluValid;
    logic [ADDR_WIDTH-1:0] i_aluRd;
    logic [XLEN-1:0]       i_aluData;
    logic                  i_lsuValid;
    logic                  o_lsuReady;
    logic [ADDR_WIDTH-1:0] i_lsuRd;
    logic [XLEN-1:0]       i_lsuData;
    logic                  o_aluStall;
    logic                  o_wrEn;
    logic [ADDR_WIDTH-1:0] o_rdAddr;
    logic [XLEN-1:0]       o_rdData;
    wb_src_e               o_wbSrc;
    logic                  o_pending;

    modport slave (
        input  i_aluValid, i_aluRd, i_aluData,
        input  i_lsuValid, i_lsuRd, i_lsuData,
        output o_lsuReady, o_aluStall,
        output o_wrEn, o_rdAddr, o_rdData,
        output o_wbSrc, o_pending
    );

    modport master (
        output i_aluValid, i_aluRd, i_aluData,
        output i_lsuValid, i_lsuRd, i_lsuData,
        input  o_lsuReady, o_aluStall,
        input  o_wrEn, o_rdAddr, o_rdData,
        input  o_wbSrc, o_pending
    );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Synchronous FIFO holding LSU {rd, data} results awaiting writeback.
module wb_arbiter_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_empty,
    output logic [clog2(DEPTH+1)-1:0]    o_count
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;

    // Pointers are log2(DEPTH) wide, so they wrap on their own.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (i_push) begin
                mem_q[wr_q] <= i_data;
                wr_q        <= wr_q + 1'b1;
            end
            if (i_pop) rd_q <= rd_q + 1'b1;
            case ({i_push, i_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign o_data  = mem_q[rd_q];
    assign o_empty = (cnt_q == '0);
    assign o_count = cnt_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win, LSU results queue, starvation forces a drain.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int XLEN         = DEF_XLEN,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    wb_arbiter_if.slave bus
);

    localparam int EW = ADDR_WIDTH + XLEN;
    localparam int CW = clog2(FIFO_DEPTH + 1);
    localparam int SW = clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic            push, pop, empty, ready, aluLive;
    logic [CW-1:0]   count;
    logic [EW-1:0]   head;

    logic                  wrEn_q, wrEn_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       data_q, data_d;
    wb_src_e               src_q, src_d;
    logic                  stall_q, stall_d;
    logic [SW-1:0]         starve_q, starve_d;

    assign ready   = (count != FULL_CNT);
    assign aluLive = bus.i_aluValid && (bus.i_aluRd != '0) && !stall_q;
    assign push    = bus.i_lsuValid && ready && (bus.i_lsuRd != '0);
    assign pop     = !aluLive && !empty;

    wb_arbiter_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  ({bus.i_lsuRd, bus.i_lsuData}),
        .o_data  (head),
        .o_empty (empty),
        .o_count (count)
    );

    always_comb begin
        wrEn_d = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        src_d  = src_q;
        if (aluLive) begin
            wrEn_d = 1'b1;
            addr_d = bus.i_aluRd;
            data_d = bus.i_aluData;
            src_d  = WB_SRC_ALU;
        end else if (pop) begin
            wrEn_d = 1'b1;
            addr_d = head[EW-1 -: ADDR_WIDTH];
            data_d = head[XLEN-1:0];
            src_d  = WB_SRC_LSU;
        end
        // Non-empty without a pop means the ALU won this cycle.
        if (empty || pop) starve_d = '0;
        else              starve_d = starve_q + 1'b1;
        stall_d = (starve_d == STARVE_MAX);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wrEn_q   <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            src_q    <= WB_SRC_ALU;
            stall_q  <= 1'b0;
            starve_q <= '0;
        end else begin
            wrEn_q   <= wrEn_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            src_q    <= src_d;
            stall_q  <= stall_d;
            starve_q <= starve_d;
        end
    end

    assign bus.o_lsuReady = ready;
    assign bus.o_aluStall = stall_q;
    assign bus.o_wrEn     = wrEn_q;
    assign bus.o_rdAddr   = addr_q;
    assign bus.o_rdData   = data_q;
    assign bus.o_wbSrc    = src_q;
    assign bus.o_pending  = !empty;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;

    logic clk;
    logic rstn;
    int   n_chk;
    int   n_fail;

    wb_arbiter_if #(.XLEN(32), .ADDR_WIDTH(5)) bus ();

    wb_arbiter #(
        .XLEN         (32),
        .ADDR_WIDTH   (5),
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (4)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic alu(input logic v, input logic [4:0] rd,
                       input logic [31:0] d);
        bus.i_aluValid = v;
        bus.i_aluRd    = rd;
        bus.i_aluData  = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] rd,
                       input logic [31:0] d);
        bus.i_lsuValid = v;
        bus.i_lsuRd    = rd;
        bus.i_lsuData  = d;
    endtask

    task automatic wr(input string tag, input logic [4:0] rd,
                      input logic [31:0] d, input logic src);
        check({tag, ".wrEn"}, bus.o_wrEn, 1'b1);
        check({tag, ".addr"}, bus.o_rdAddr, rd);
        check({tag, ".data"}, bus.o_rdData, d);
        check({tag, ".src"}, bus.o_wbSrc, src);
    endtask

    task automatic zero_outs(input string tag);
        check({tag, ".wrEn"}, bus.o_wrEn, 1'b0);
        check({tag, ".addr"}, bus.o_rdAddr, 5'd0);
        check({tag, ".data"}, bus.o_rdData, 32'd0);
        check({tag, ".src"}, bus.o_wbSrc, 1'b0);
        check({tag, ".stall"}, bus.o_aluStall, 1'b0);
        check({tag, ".pend"}, bus.o_pending, 1'b0);
        check({tag, ".rdy"}, bus.o_lsuReady, 1'b1);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rstn   = 1'b0;
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        step();
        step();
        zero_outs("rst");
        rstn = 1'b1;
        step();

        // ALU only
        alu(1'b1, 5'd5, 32'hDEADBEEF);
        step();
        wr("alu5", 5'd5, 32'hDEADBEEF, 1'b0);
        alu(1'b1, 5'd0, 32'h123);
        step();
        check("alu_x0.wrEn", bus.o_wrEn, 1'b0);
        check("alu_x0.hold", bus.o_rdData, 32'hDEADBEEF);
        alu(1'b0, 5'd0, 32'd0);

        // LSU only
        lsu(1'b1, 5'd7, 32'h11);
        check("lsu.rdy", bus.o_lsuReady, 1'b1);
        step();
        lsu(1'b0, 5'd0, 32'd0);
        check("lsu.pend1", bus.o_pending, 1'b1);
        check("lsu.nowr", bus.o_wrEn, 1'b0);
        step();
        wr("lsu7", 5'd7, 32'h11, 1'b1);
        check("lsu.pend0", bus.o_pending, 1'b0);
        step();
        check("lsu.idle", bus.o_wrEn, 1'b0);

        // Fill FIFO under continuous ALU traffic
        for (int k = 0; k < 4; k++) begin
            alu(1'b1, 5'(k + 1), 32'hA0 + k);
            lsu(1'b1, 5'(k + 8), 32'h80 + 32'(k * 16));
            step();
            wr("fill", 5'(k + 1), 32'hA0 + k, 1'b0);
        end
        check("full.rdy", bus.o_lsuReady, 1'b0);
        check("full.pend", bus.o_pending, 1'b1);
        alu(1'b1, 5'd5, 32'hA5);
        lsu(1'b1, 5'd12, 32'hC0);
        step();
        wr("full.alu5", 5'd5, 32'hA5, 1'b0);
        check("full.rdy5", bus.o_lsuReady, 1'b0);
        check("full.stall", bus.o_aluStall, 1'b1);
        alu(1'b1, 5'd6, 32'hA6);
        step();
        wr("full.pop8", 5'd8, 32'h80, 1'b1);
        check("full.unstall", bus.o_aluStall, 1'b0);
        check("full.rdy3", bus.o_lsuReady, 1'b1);
        step();
        wr("full.alu6", 5'd6, 32'hA6, 1'b0);
        check("full.rdy4", bus.o_lsuReady, 1'b0);
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        for (int k = 1; k < 5; k++) begin
            step();
            wr("drain", 5'(k + 8), 32'h80 + 32'(k * 16), 1'b1);
        end
        check("drain.pend", bus.o_pending, 1'b0);
        step();
        check("drain.idle", bus.o_wrEn, 1'b0);

        // Starvation with one queued entry
        lsu(1'b1, 5'd20, 32'h2000);
        for (int k = 0; k < 5; k++) begin
            alu(1'b1, 5'(k + 3), 32'h300 + k);
            step();
            lsu(1'b0, 5'd0, 32'd0);
            wr("starve.alu", 5'(k + 3), 32'h300 + k, 1'b0);
        end
        check("starve.stall", bus.o_aluStall, 1'b1);
        alu(1'b1, 5'd8, 32'h308);
        step();
        wr("starve.lsu", 5'd20, 32'h2000, 1'b1);
        check("starve.unstall", bus.o_aluStall, 1'b0);
        step();
        wr("starve.held", 5'd8, 32'h308, 1'b0);
        alu(1'b0, 5'd0, 32'd0);
        step();
        check("starve.idle", bus.o_wrEn, 1'b0);
        check("starve.pend", bus.o_pending, 1'b0);

        // ALU to x0 lets the FIFO pop; LSU to x0 is swallowed
        alu(1'b1, 5'd1, 32'h1);
        lsu(1'b1, 5'd15, 32'hF);
        step();
        alu(1'b1, 5'd0, 32'hBAD);
        lsu(1'b1, 5'd0, 32'hBAD);
        check("x0.pend1", bus.o_pending, 1'b1);
        step();
        wr("x0.pop", 5'd15, 32'hF, 1'b1);
        check("x0.pend0", bus.o_pending, 1'b0);
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        step();
        check("x0.idle", bus.o_wrEn, 1'b0);
        check("x0.pend", bus.o_pending, 1'b0);

        // Async reset with three entries queued
        for (int k = 0; k < 3; k++) begin
            alu(1'b1, 5'(k + 1), 32'hE0 + k);
            lsu(1'b1, 5'(k + 21), 32'hD0 + k);
            step();
        end
        lsu(1'b0, 5'd0, 32'd0);
        check("mid.pend", bus.o_pending, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        zero_outs("mid.rst");
        alu(1'b0, 5'd0, 32'd0);
        step();
        rstn = 1'b1;
        step();
        check("post.wrEn", bus.o_wrEn, 1'b0);
        check("post.pend", bus.o_pending, 1'b0);
        step();
        check("post.wrEn2", bus.o_wrEn, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
